// File: rtl/serial_collect_if.sv
// ============================================================================
// Module      : serial_collect_if
// Description : Bundles the serial input handshake and the parallel word
//               output of serial_collect. Declare it with the same W as the
//               serial_collect instance it connects to.
//               Optional feature macro: SERIAL_COLLECT_PARITY_EN adds par_o.
// Signals     : in_bit, in_valid, in_start, out_ready  (toward collector)
//               word_o[W-1:0], out_valid, busy, frame_err, ovf, par_o
//                                                      (from collector)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_collect_if #(
  parameter int W = 8
);
  logic         in_bit;
  logic         in_valid;
  logic         in_start;
  logic         out_ready;
  logic [W-1:0] word_o;
  logic         out_valid;
  logic         busy;
  logic         frame_err;
  logic         ovf;
`ifdef SERIAL_COLLECT_PARITY_EN
  logic         par_o;

  modport master (
    output in_bit, in_valid, in_start, out_ready,
    input  word_o, out_valid, busy, frame_err, ovf, par_o
  );

  modport slave (
    input  in_bit, in_valid, in_start, out_ready,
    output word_o, out_valid, busy, frame_err, ovf, par_o
  );
`else
  modport master (
    output in_bit, in_valid, in_start, out_ready,
    input  word_o, out_valid, busy, frame_err, ovf
  );

  modport slave (
    input  in_bit, in_valid, in_start, out_ready,
    output word_o, out_valid, busy, frame_err, ovf
  );
`endif
endinterface

`default_nettype wire

// File: rtl/serial_collect.sv
// ============================================================================
// Module      : serial_collect
// Description : Deserialises an LSB-first bit stream into W-bit words with a
//               one-deep output holding register and valid/ready handoff.
//               A start bit inside a partial frame aborts it (frame_err
//               pulse); a finished word arriving while the holding register
//               is still unconsumed is dropped and sets sticky ovf.
//               Optional feature macro: SERIAL_COLLECT_PARITY_EN registers
//               par_o = even parity (XOR) of word_o.
// Ports       : t_clk  - clock, rising edge
//               r_n    - asynchronous active-low reset
//               bus    - serial_collect_if.slave (serial in, word out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_collect #(
  parameter int W = 8
) (
  input  wire              t_clk,
  input  wire              r_n,
  serial_collect_if.slave  bus
);

  localparam int          c_CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(W - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [W-1:0]    r_shift;
  logic [W-1:0]    r_word;
  logic            r_out_valid;
  logic            r_frame_err;
  logic            r_ovf;
`ifdef SERIAL_COLLECT_PARITY_EN
  logic            r_par;
`endif

  // The finished word: bits collected so far plus the final bit on the wire.
  logic [W-1:0]    w_full;
  logic            w_can_load;

  always_comb begin
    w_full        = r_shift;
    w_full[W-1]   = bus.in_bit;
  end

  // Holding register is free if empty or being consumed this edge.
  assign w_can_load = !r_out_valid || bus.out_ready;

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_word      <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef SERIAL_COLLECT_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      // Consumption; a load further down overrides this back to 1.
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (bus.in_valid) begin
        if (bus.in_start) begin
          // New frame from IDLE, or abort-and-restart from SHIFT.
          if (r_state == S_SHIFT) begin
            r_frame_err <= 1'b1;
          end
          r_shift <= {{(W-1){1'b0}}, bus.in_bit};
          r_cnt   <= c_ONE;
          r_state <= S_SHIFT;
        end else if (r_state == S_SHIFT) begin
          if (r_cnt == c_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (w_can_load) begin
              r_word      <= w_full;
              r_out_valid <= 1'b1;
`ifdef SERIAL_COLLECT_PARITY_EN
              r_par       <= ^w_full;
`endif
            end else begin
              r_ovf <= 1'b1;
            end
          end else begin
            r_shift[r_cnt] <= bus.in_bit;
            r_cnt          <= r_cnt + c_ONE;
          end
        end
      end
    end
  end

  assign bus.word_o    = r_word;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state == S_SHIFT);
  assign bus.frame_err = r_frame_err;
  assign bus.ovf       = r_ovf;
`ifdef SERIAL_COLLECT_PARITY_EN
  assign bus.par_o     = r_par;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_collect.sv
// ============================================================================
// Module      : tb_serial_collect
// Description : Self-checking bench for serial_collect (W=8). Directed
//               scenarios plus randomized traffic, all checked every cycle
//               against a frame-level reference model (bit queue per frame,
//               one-word output slot, sticky overflow).
//               Honours SERIAL_COLLECT_PARITY_EN for the par_o check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_collect;

  localparam int W = 8;

  logic t_clk = 1'b0;
  logic r_n   = 1'b0;

  always #5 t_clk = ~t_clk;

  serial_collect_if #(.W(W)) bus ();

  serial_collect #(.W(W)) dut (
    .t_clk (t_clk),
    .r_n   (r_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit           m_frame[$];
  logic [W-1:0] m_word;
  logic         m_valid;
  logic         m_ferr;
  logic         m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_word  = '0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock edge of behaviour, expressed at frame level.
  task automatic model_edge(input bit b, input bit v, input bit s, input bit rdy);
    logic [W-1:0] w;
    bit consumed;
    consumed = m_valid && rdy;
    m_ferr   = 1'b0;
    if (v) begin
      if (s) begin
        if (m_frame.size() > 0) m_ferr = 1'b1;
        m_frame.delete();
        m_frame.push_back(b);
      end else if (m_frame.size() > 0) begin
        m_frame.push_back(b);
        if (m_frame.size() == W) begin
          w = '0;
          for (int i = 0; i < W; i++) w[i] = m_frame[i];
          m_frame.delete();
          if (!m_valid || rdy) begin
            m_word   = w;
            m_valid  = 1'b1;
            consumed = 1'b0;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
    if (consumed) m_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".word"},  32'(bus.word_o),    32'(m_word));
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".busy"},  32'(bus.busy),      32'(m_frame.size() > 0));
    chk({tag, ".ferr"},  32'(bus.frame_err), 32'(m_ferr));
    chk({tag, ".ovf"},   32'(bus.ovf),       32'(m_ovf));
`ifdef SERIAL_COLLECT_PARITY_EN
    chk({tag, ".par"},   32'(bus.par_o),     32'($countones(m_word) % 2));
`endif
  endtask

  task automatic step(input bit b, input bit v, input bit s, input bit rdy, input string tag);
    @(negedge t_clk);
    bus.in_bit    = b;
    bus.in_valid  = v;
    bus.in_start  = s;
    bus.out_ready = rdy;
    @(posedge t_clk);
    model_edge(b, v, s, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy, input string tag);
    for (int i = 0; i < W; i++) step(w[i], 1'b1, i == 0, rdy, tag);
  endtask

  // Asynchronous reset a little after a rising edge, released on a falling edge.
  task automatic async_reset(input string tag);
    @(posedge t_clk);
    #2;
    r_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge t_clk);
    r_n = 1'b1;
  endtask

  initial begin
    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_start  = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    // Random junk on the inputs during reset must not be sampled.
    repeat (3) begin
      @(negedge t_clk);
      bus.in_bit   = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_start = 1'b1;
    end
    #1;
    check_all("reset");
    @(negedge t_clk);
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    r_n = 1'b1;

    // 0xEC with ready held high: one-cycle valid pulse.
    send_word(8'hEC, 1'b1, "ec");
    chk("ec_word", 32'(bus.word_o), 32'h00EC);
    chk("ec_valid", 32'(bus.out_valid), 32'd1);
`ifdef SERIAL_COLLECT_PARITY_EN
    chk("ec_par", 32'(bus.par_o), 32'd1);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, "ec_after");
    chk("ec_pulse", 32'(bus.out_valid), 32'd0);

    // 0x01 with two gaps inside the frame.
    for (int i = 0; i < W; i++) begin
      step(i == 0, 1'b1, i == 0, 1'b1, "gap");
      if (i == 3) begin
        step(1'b1, 1'b0, 1'b0, 1'b1, "gap_idle");
        step(1'b1, 1'b0, 1'b1, 1'b1, "gap_idle");
      end
    end
    chk("gap_word", 32'(bus.word_o), 32'h0001);
    chk("gap_valid", 32'(bus.out_valid), 32'd1);

    // Abort after 3 bits, restart with 0x81.
    step(1'b1, 1'b1, 1'b1, 1'b1, "abort");
    step(1'b0, 1'b1, 1'b0, 1'b1, "abort");
    step(1'b1, 1'b1, 1'b0, 1'b1, "abort");
    step(1'b1, 1'b1, 1'b1, 1'b1, "abort_start");
    chk("abort_ferr", 32'(bus.frame_err), 32'd1);
    for (int i = 1; i < W; i++) step(i == W - 1, 1'b1, 1'b0, 1'b1, "abort_rest");
    chk("abort_word", 32'(bus.word_o), 32'h0081);

    // Start on the final bit position: no completion.
    for (int i = 0; i < W - 1; i++) step(1'b1, 1'b1, i == 0, 1'b1, "late");
    step(1'b0, 1'b1, 1'b1, 1'b1, "late_start");
    chk("late_ferr", 32'(bus.frame_err), 32'd1);
    chk("late_busy", 32'(bus.busy), 32'd1);
    for (int i = 1; i < W; i++) step(1'b0, 1'b1, 1'b0, 1'b1, "late_rest");

    // Overflow with ready low.
    step(1'b0, 1'b0, 1'b0, 1'b1, "drain");
    send_word(8'h5A, 1'b0, "ovf_a");
    send_word(8'hA5, 1'b0, "ovf_b");
    chk("ovf_word", 32'(bus.word_o), 32'h005A);
    chk("ovf_flag", 32'(bus.ovf), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "ovf_take");
    chk("ovf_valid_clr", 32'(bus.out_valid), 32'd0);
    chk("ovf_sticky", 32'(bus.ovf), 32'd1);

    // Back-to-back, ready pulsed on the second completion edge.
    send_word(8'h33, 1'b0, "b2b_a");
    for (int i = 0; i < W; i++) step(i[0], 1'b1, i == 0, i == W - 1, "b2b_b");
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_word", 32'(bus.word_o), 32'h00AA);

    // Reset mid-frame, then a clean 0x3C.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 1'b0, "mid");
    async_reset("mid_reset");
    send_word(8'h3C, 1'b1, "post_reset");
    chk("post_word", 32'(bus.word_o), 32'h003C);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset("rnd_reset");
      end else begin
        step(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
             $urandom_range(0, 3) != 0, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_collect.md
SERIAL_COLLECT -- requirements
Module: serial_collect

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the deserialised word width in bits (legal range 2..32).
REQ-002 Port t_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port r_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 Port in_bit  input  1  serial data bit from the upstream serial two's complementer, LSB first.
REQ-005 Port in_valid  input  1  in_bit is meaningful this cycle.
REQ-006 Port in_start  input  1  qualified by in_valid; marks bit 0 of a new word.
REQ-007 Port out_ready  input  1  downstream accepts the held word this cycle.
REQ-008 Port word_o  output  W  assembled word, bit 0 = first serial bit.
REQ-009 Port out_valid  output  1  word_o holds an unconsumed word.
REQ-010 Port busy  output  1  a frame is partially assembled (state SHIFT).
REQ-011 Port frame_err  output  1  one-cycle pulse when a frame is aborted by an early in_start.
REQ-012 Port ovf  output  1  sticky flag: a completed word was dropped because the holding register was full.
REQ-013 Port par_o  output  1  even-parity bit of word_o; present only when SERIAL_COLLECT_PARITY_EN is defined.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SHIFT; the bit counter cnt SHALL be ceil(log2(W)) bits wide.
REQ-015 In IDLE, in_valid=1 with in_start=1 SHALL load in_bit into shift bit 0, set cnt=1 and enter SHIFT; in_valid with in_start=0 SHALL be ignored.
REQ-016 In SHIFT, in_valid=1 with in_start=0 SHALL store in_bit at position cnt and increment cnt; cycles with in_valid=0 SHALL hold all state.
REQ-017 On the edge accepting bit W-1, the FSM SHALL return to IDLE and cnt SHALL wrap to 0.
REQ-018 On that edge, if out_valid=0 or out_ready=1, word_o SHALL load the complete word and out_valid SHALL be 1 from the next cycle (latency 1 cycle after the last bit).
REQ-019 On that edge, if out_valid=1 and out_ready=0, the new word SHALL be discarded, word_o SHALL remain unchanged, and ovf SHALL be set.
REQ-020 out_valid SHALL clear on an edge where out_valid=1 and out_ready=1, unless a new word loads on the same edge per REQ-018, in which case it SHALL stay 1.
REQ-021 In SHIFT, in_valid=1 with in_start=1 SHALL discard the partial word, pulse frame_err for one cycle, and restart as in REQ-015 (in_bit becomes the new bit 0).
REQ-022 in_start arriving on the same edge as bit W-1 SHALL be treated per REQ-021; no word SHALL complete.
REQ-023 busy SHALL equal 1 exactly while in SHIFT.
REQ-024 word_o SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-025 r_n=0 SHALL immediately force IDLE, cnt=0, the shift register to 0, word_o=0, out_valid=0, busy=0, frame_err=0, ovf=0, and par_o=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial word with no frame_err pulse; ovf SHALL clear only by reset.
REQ-027 Deassertion of r_n SHALL take effect at the first rising t_clk after release, with no inputs sampled before that edge.

Configuration
REQ-028 With SERIAL_COLLECT_PARITY_EN defined, par_o SHALL be the XOR of all W bits of the word, registered on the same edge as word_o.
REQ-029 Without SERIAL_COLLECT_PARITY_EN, port par_o and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 W=8, out_ready=1: send 0xEC LSB-first (0,0,1,1,0,1,1,1) with in_start on the first bit -> word_o=0xEC, out_valid=1 for exactly one cycle starting one cycle after the 8th bit, par_o=1.
REQ-031 Send 0x01, then two idle cycles inside the frame (in_valid=0) -> word_o=0x01, and completion is delayed by exactly 2 cycles.
REQ-032 Send 3 bits, then assert in_start with bit 1 followed by 7 more bits of 0x81 -> frame_err=1 for one cycle, then word_o=0x81.
REQ-033 With out_ready=0, send 0x5A, then 0xA5 -> word_o stays 0x5A, ovf=1; raising out_ready clears out_valid but not ovf.
REQ-034 Assert r_n=0 after 5 bits of a frame -> all outputs 0 immediately; a new full frame of 0x3C after release yields word_o=0x3C.
REQ-035 Word back-to-back with out_ready pulsed on the completion edge -> out_valid stays 1 and word_o updates to the second word.
